// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types, sizes and PC helpers for the instruction fetch stage.
//   PC_W / INSTR_W : PC and instruction widths
//   PROG_DEPTH     : number of valid memory words (PC wraps inside this range)
//   RESET_PC       : PC value loaded on reset
package fetch_pkg;
    localparam int PC_W       = 8;
    localparam int INSTR_W    = 8;
    localparam int PROG_DEPTH = 16;
    localparam int RESET_PC   = 0;

    typedef logic [PC_W-1:0]    pc_t;
    typedef logic [INSTR_W-1:0] instr_t;

    // Sequential successor with wrap at the end of program memory.
    function automatic pc_t next_pc(input pc_t pc);
        return (pc == pc_t'(PROG_DEPTH - 1)) ? '0 : pc + pc_t'(1);
    endfunction

    // Out-of-range redirect targets fold back into program memory.
    function automatic pc_t wrap_pc(input pc_t pc);
        return pc % pc_t'(PROG_DEPTH);
    endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: memory, redirect and IF/ID handshake signals of the fetch stage.
//   master : fetch stage side (drives PC and the IF/ID entry)
//   slave  : environment side (memory, execute and decode)
interface fetch_stage_if import fetch_pkg::*; ();
    pc_t    PC;
    instr_t Instruction_Code;
    logic   Redirect;
    pc_t    Redirect_PC;
    logic   ID_Valid;
    logic   ID_Ready;
    instr_t ID_Instr;
    pc_t    ID_PC;

    modport master (
        output PC, ID_Valid, ID_Instr, ID_PC,
        input  Instruction_Code, Redirect, Redirect_PC, ID_Ready
    );
    modport slave (
        input  PC, ID_Valid, ID_Instr, ID_PC,
        output Instruction_Code, Redirect, Redirect_PC, ID_Ready
    );
endinterface

// File: rtl/fetch_stage_pc_reg.sv
// pc_reg: program counter register.
//   Clk, Reset (sync, active low), Enable : clock / reset / run enable
//   Redirect, Redirect_PC                 : jump target from execute
//   Advance                               : IF/ID accepted a fetch this cycle
//   PC                                    : registered program counter
// Priority: reset, then redirect (only while enabled), then advance, else hold.
module pc_reg import fetch_pkg::*; (
    input  logic Clk,
    input  logic Reset,
    input  logic Enable,
    input  logic Redirect,
    input  pc_t  Redirect_PC,
    input  logic Advance,
    output pc_t  PC
);
    always_ff @(posedge Clk) begin
        if (!Reset)
            PC <= pc_t'(RESET_PC);
        else if (Enable && Redirect)
            PC <= wrap_pc(Redirect_PC);
        else if (Advance)
            PC <= next_pc(PC);
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with a single-entry IF/ID register.
//   Clk, Reset (sync, active low) : clock / reset
//   Enable                        : run enable; low holds PC and IF/ID
//   bus (fetch_stage_if.master)   : PC/Instruction_Code memory port,
//                                   Redirect/Redirect_PC from execute,
//                                   ID_Valid/ID_Ready/ID_Instr/ID_PC to decode
//   Fetch_Count, Flush_Count      : saturating perf counters, only when
//                                   FETCH_PERF_EN is defined
module fetch_stage import fetch_pkg::*; (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Enable,
`ifdef FETCH_PERF_EN
    output logic [15:0]   Fetch_Count,
    output logic [15:0]   Flush_Count,
`endif
    fetch_stage_if.master bus
);
    pc_t    pc;
    logic   id_valid;
    instr_t id_instr;
    pc_t    id_pc;
    logic   xfer, adv, advance;

    assign xfer    = id_valid && bus.ID_Ready;
    assign adv     = Enable && (!id_valid || bus.ID_Ready);
    assign advance = adv && !bus.Redirect;

    pc_reg u_pc_reg (
        .Clk         (Clk),
        .Reset       (Reset),
        .Enable      (Enable),
        .Redirect    (bus.Redirect),
        .Redirect_PC (bus.Redirect_PC),
        .Advance     (advance),
        .PC          (pc)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            id_valid <= 1'b0;
            id_instr <= '0;
            id_pc    <= '0;
        end else if (!Enable) begin
            // Decode may still drain the held entry while fetch is frozen.
            if (xfer)
                id_valid <= 1'b0;
        end else if (bus.Redirect) begin
            // Wrong-path fetch is dropped; the old entry is flushed.
            id_valid <= 1'b0;
        end else if (adv) begin
            id_valid <= 1'b1;
            id_instr <= bus.Instruction_Code;
            id_pc    <= pc;
        end
    end

    assign bus.PC       = pc;
    assign bus.ID_Valid = id_valid;
    assign bus.ID_Instr = id_instr;
    assign bus.ID_PC    = id_pc;

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_cnt, flush_cnt;
    logic        flush;

    // A flush only counts when the entry is lost, not when decode took it.
    assign flush = Enable && bus.Redirect && id_valid && !bus.ID_Ready;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (advance && fetch_cnt != 16'hFFFF)
                fetch_cnt <= fetch_cnt + 16'd1;
            if (flush && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end

    assign Fetch_Count = fetch_cnt;
    assign Flush_Count = flush_cnt;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table, wrap sequence and randomized run of
// fetch_stage against a cycle-level reference model of the fetch rules.
module tb_fetch_stage;
    logic Clk = 1'b0;
    logic Reset, Enable;
`ifdef FETCH_PERF_EN
    logic [15:0] Fetch_Count, Flush_Count;
`endif

    fetch_stage_if bus();

    logic [7:0] mem [16];
    assign bus.Instruction_Code = mem[bus.PC[3:0]];

    fetch_stage dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Enable (Enable),
`ifdef FETCH_PERF_EN
        .Fetch_Count (Fetch_Count),
        .Flush_Count (Flush_Count),
`endif
        .bus    (bus)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int   m_pc, m_idpc;
    bit   m_v;
    int   m_instr;
    int   m_fetch, m_flush;

    typedef struct {
        bit       r, en, rd;
        int       rpc;
        bit       rdy;
        bit       ev;
        int       epc, eidpc, einstr;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(bit r, bit en, bit rd, int rpc, bit rdy,
                                bit ev, int epc, int eidpc, int einstr);
        vec_t v;
        v.r = r; v.en = en; v.rd = rd; v.rpc = rpc; v.rdy = rdy;
        v.ev = ev; v.epc = epc; v.eidpc = eidpc; v.einstr = einstr;
        tbl.push_back(v);
    endfunction

    // Apply one cycle of inputs, advance the model, compare DUT against model.
    task automatic step(input bit r, input bit en, input bit rd, input int rpc,
                        input bit rdy, input string name);
        bit ok;
        Reset = r; Enable = en; bus.Redirect = rd;
        bus.Redirect_PC = 8'(rpc); bus.ID_Ready = rdy;
        // model: one cycle of the fetch rules
        if (!r) begin
            m_pc = 0; m_v = 0; m_instr = 0; m_idpc = 0; m_fetch = 0; m_flush = 0;
        end else if (!en) begin
            if (m_v && rdy) m_v = 0;
        end else if (rd) begin
            if (m_v && !rdy && m_flush < 65535) m_flush++;
            m_pc = rpc % 16;
            m_v = 0;
        end else if (!m_v || rdy) begin
            m_instr = mem[m_pc];
            m_idpc = m_pc;
            m_v = 1;
            m_pc = (m_pc + 1) % 16;
            if (m_fetch < 65535) m_fetch++;
        end
        @(posedge Clk);
        #1;
        checks++;
        ok = (bus.ID_Valid == m_v) && (int'(bus.PC) == m_pc);
        if (m_v) ok = ok && (int'(bus.ID_PC) == m_idpc) && (int'(bus.ID_Instr) == m_instr);
        if (!r) ok = ok && (bus.ID_PC == 0) && (bus.ID_Instr == 0);
`ifdef FETCH_PERF_EN
        ok = ok && (int'(Fetch_Count) == m_fetch) && (int'(Flush_Count) == m_flush);
`endif
        if (!ok) begin
            failures++;
            $display("FAIL %s: got v=%0d pc=%0h idpc=%0h instr=%0h, expected v=%0d pc=%0h idpc=%0h instr=%0h",
                     name, bus.ID_Valid, bus.PC, bus.ID_PC, bus.ID_Instr, m_v, m_pc, m_idpc, m_instr);
        end
`ifdef FETCH_PERF_EN
        if (!ok)
            $display("  counters got fetch=%0d flush=%0d, expected fetch=%0d flush=%0d",
                     Fetch_Count, Flush_Count, m_fetch, m_flush);
`endif
    endtask

    task automatic check_vec(input vec_t v, input int idx);
        bit ok;
        checks++;
        ok = (bus.ID_Valid == v.ev) && (int'(bus.PC) == v.epc) &&
             (int'(bus.ID_PC) == v.eidpc) && (int'(bus.ID_Instr) == v.einstr);
        if (!ok) begin
            failures++;
            $display("FAIL vec%0d: got v=%0d pc=%0h idpc=%0h instr=%0h, expected v=%0d pc=%0h idpc=%0h instr=%0h",
                     idx, bus.ID_Valid, bus.PC, bus.ID_PC, bus.ID_Instr, v.ev, v.epc, v.eidpc, v.einstr);
        end
    endtask

    initial begin
        int n;
        mem = '{8'h2b, 8'h6a, 8'h63, 8'ha7, 8'h14, 8'h5c, 8'hc3, 8'h09,
                8'hf0, 8'h81, 8'h3e, 8'hd2, 8'h77, 8'hb5, 8'h4f, 8'he8};
        Reset = 0; Enable = 0; bus.Redirect = 0; bus.Redirect_PC = 0; bus.ID_Ready = 0;
        m_pc = 0; m_v = 0; m_instr = 0; m_idpc = 0; m_fetch = 0; m_flush = 0;

        //  r en rd rpc rdy | ev  pc idpc instr
        add(0, 0, 0, 0,    0,   0, 0, 0, 8'h00);   // reset 2 cycles
        add(0, 0, 0, 0,    0,   0, 0, 0, 8'h00);
        add(1, 1, 0, 0,    1,   1, 1, 0, 8'h2b);   // streaming
        add(1, 1, 0, 0,    1,   1, 2, 1, 8'h6a);
        add(1, 1, 0, 0,    1,   1, 3, 2, 8'h63);
        add(0, 1, 0, 0,    1,   0, 0, 0, 8'h00);   // reset clears entry
        add(1, 1, 0, 0,    1,   1, 1, 0, 8'h2b);
        add(1, 1, 0, 0,    1,   1, 2, 1, 8'h6a);
        add(1, 1, 0, 0,    0,   1, 2, 1, 8'h6a);   // stall 3 cycles
        add(1, 1, 0, 0,    0,   1, 2, 1, 8'h6a);
        add(1, 1, 0, 0,    0,   1, 2, 1, 8'h6a);
        add(1, 1, 0, 0,    1,   1, 3, 2, 8'h63);   // resume
        add(1, 1, 0, 0,    0,   1, 3, 2, 8'h63);   // stalled
        add(1, 1, 1, 4,    0,   0, 4, 2, 8'h63);   // redirect flushes
        add(1, 1, 0, 0,    1,   1, 5, 4, 8'h14);
        add(1, 1, 0, 0,    0,   1, 5, 4, 8'h14);   // stall at PC=5
        add(0, 0, 1, 9,    0,   0, 0, 0, 8'h00);   // reset beats redirect/enable
        add(1, 1, 0, 0,    1,   1, 1, 0, 8'h2b);
        add(1, 1, 1, 8'h13, 1,  0, 3, 0, 8'h2b);   // target 19 folds to 3
        add(1, 1, 0, 0,    1,   1, 4, 3, 8'ha7);
        add(1, 0, 0, 0,    1,   0, 4, 3, 8'ha7);   // Enable low: drained
        add(1, 0, 1, 7,    1,   0, 4, 3, 8'ha7);   // redirect ignored
        add(1, 1, 0, 0,    1,   1, 5, 4, 8'h14);   // fetch resumes

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].en, tbl[i].rd, tbl[i].rpc, tbl[i].rdy, "vec_model");
            check_vec(tbl[i], i);
        end

        // Wrap from PC 15 back to 0, bounded.
        n = 0;
        while (m_pc != 15 && n < 40) begin
            step(1, 1, 0, 0, 1, "wrap_run");
            n++;
        end
        checks++;
        if (m_pc != 15) begin
            failures++;
            $display("FAIL wrap_bound: model pc=%0d, required 15", m_pc);
        end
        step(1, 1, 0, 0, 1, "wrap_15");
        checks++;
        if (bus.ID_PC != 8'd15 || bus.PC != 8'd0 || bus.ID_Instr != 8'he8) begin
            failures++;
            $display("FAIL wrap_15: got idpc=%0d pc=%0d instr=%0h, required idpc=15 pc=0 instr=e8",
                     bus.ID_PC, bus.PC, bus.ID_Instr);
        end
        step(1, 1, 0, 0, 1, "wrap_0");
        checks++;
        if (bus.ID_PC != 8'd0 || bus.ID_Instr != 8'h2b) begin
            failures++;
            $display("FAIL wrap_0: got idpc=%0d instr=%0h, required idpc=0 instr=2b",
                     bus.ID_PC, bus.ID_Instr);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 39) != 0,
                 $urandom_range(0, 99) < 85,
                 $urandom_range(0, 9) == 0,
                 int'($urandom_range(0, 255)),
                 $urandom_range(0, 9) < 7,
                 "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage sitting directly upstream of the 8-bit combinational instruction memory and downstream-feeding the decode stage.
- Owns the program counter and drives the memory address.
- Captures the returned instruction code into a single-entry IF/ID register, with a valid/ready handshake to decode.
- Accepts a redirect (jump/branch) from execute that flushes the in-flight entry.

Parameters:
- PC_W, 8, width of program counter and memory address.
- INSTR_W, 8, width of instruction code.
- PROG_DEPTH, 16, number of valid memory words; PC wraps from PROG_DEPTH-1 to 0.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-low reset; sampled on rising edge of Clk.
- Enable  input  1  global run enable; when low, PC and IF/ID register hold.
- PC  output  PC_W  address to instruction memory (registered PC).
- Instruction_Code  input  INSTR_W  combinational read data from instruction memory for current PC.
- Redirect  input  1  execute requests PC change (taken jump/branch).
- Redirect_PC  input  PC_W  target address for Redirect.
- ID_Valid  output  1  IF/ID register holds a valid instruction.
- ID_Ready  input  1  decode accepts the IF/ID entry this cycle.
- ID_Instr  output  INSTR_W  registered instruction.
- ID_PC  output  PC_W  address the registered instruction was fetched from.

Behaviour:
- Reset (Reset==0 at rising edge): PC<=RESET_PC, ID_Valid<=0, ID_Instr<=0, ID_PC<=0. Reset overrides Redirect, Enable and the handshake.
- First fetch: Instruction_Code for RESET_PC is captured on the first rising edge with Reset==1 and Enable==1.
- Advance condition: adv = Enable && (!ID_Valid || ID_Ready).
- Redirect (Reset==1, Enable==1, Redirect==1), highest priority after reset:
  - PC<=Redirect_PC mod PROG_DEPTH; ID_Valid<=0.
  - The current Instruction_Code is discarded, and any entry presented to decode that cycle is flushed.
  - Redirect is ignored while Enable==0.
- Advance (adv and no Redirect):
  - ID_Instr<=Instruction_Code; ID_PC<=PC; ID_Valid<=1.
  - PC<=(PC==PROG_DEPTH-1) ? 0 : PC+1.
- Stall (Enable==1, ID_Valid==1, ID_Ready==0, no Redirect): PC, ID_Instr, ID_PC and ID_Valid all hold. ID_Instr and ID_PC stay stable while ID_Valid is high and ID_Ready is low.
- Enable==0: all state holds, including ID_Valid. Decode may still complete a transfer when ID_Ready==1; the entry is then consumed, so ID_Valid<=0.
- Throughput: one instruction per cycle when ID_Ready is held high. Latency from PC update to ID_Valid is 1 cycle.
- Redirect_PC >= PROG_DEPTH: reduced modulo PROG_DEPTH; no error is raised.
- Simultaneous Redirect with ID_Valid && ID_Ready: decode consumes the old entry that cycle, and the next cycle shows ID_Valid==0.
- PC output always equals the registered PC; there is no combinational path from Redirect to PC.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds outputs Fetch_Count[15:0] and Flush_Count[15:0], both reset to 0.
  - Fetch_Count increments on every advance.
  - Flush_Count increments when Redirect fires while ID_Valid==1 and no transfer occurs that cycle.
  - Both counters saturate at 16'hFFFF.
- Undefined: neither the ports nor the counter logic exist; all other behaviour is identical.

Decomposition:
- Shared package fetch_pkg holds:
  - localparams PC_W, INSTR_W, PROG_DEPTH, RESET_PC;
  - typedef pc_t (PC_W bits);
  - typedef instr_t (INSTR_W bits);
  - function next_pc(pc_t) implementing the wrap rule.
- One natural sub-module, pc_reg: holds the PC and implements reset, the redirect/increment/hold mux and the wrap rule.
- The IF/ID register and handshake stay in fetch_stage.

Test Plan:
- Reset low 2 cycles, then high with ID_Ready=1, Enable=1, memory 0:2b,1:6a,2:63 -> ID_Valid=1 next edge with (ID_PC,ID_Instr)=(0,2b), then (1,6a), then (2,63) on consecutive cycles.
- ID_Ready=0 for 3 cycles after entry (1,6a) -> ID_Instr=6a, ID_PC=1 and PC=2 held stable all 3 cycles; resumes at (2,63) one cycle after ID_Ready=1.
- Run to PC=15 -> next advance yields ID_PC=15 and PC=0; the following entry has ID_PC=0.
- Redirect=1 with Redirect_PC=4 while ID_Valid=1 and ID_Ready=0 -> next cycle ID_Valid=0 and PC=4; following cycle ID_PC=4 with ID_Instr=14. With FETCH_PERF_EN, Flush_Count=1.
- Reset driven low mid-stall with ID_Valid=1 and PC=5 -> next edge PC=0 and ID_Valid=0, regardless of Redirect=1 or Enable=0 on that cycle.
- Enable=0 for 2 cycles while ID_Valid=1 and ID_Ready=1 -> entry consumed, so ID_Valid=0; PC unchanged; fetch resumes the cycle Enable returns high.
